// File: rtl/ram_pkg.sv
// Shared constants, clear-FSM state type and sizing helpers for the SDP byte-enable RAM.
package ram_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic int unsigned num_bytes(input int unsigned dw, input int unsigned bw);
        return dw / bw;
    endfunction

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Post-reset sweep: walks every address once, asserting a zero-write strobe per cycle.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam int unsigned DEPTH = depth(ADDR_WIDTH);

    clr_state_e            state;
    clr_state_e            state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  busy_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nxt;
            clr_addr <= addr_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = clr_addr;
        busy_nxt  = busy;
        case (state)
            ST_CLEAR: begin
                addr_nxt = clr_addr + ADDR_WIDTH'(1);
                if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Memory is left untouched while reset is held.
    assign clr_we = (state == ST_CLEAR) && !rst;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port synchronous RAM with byte-lane write enables, configurable read
// latency, selectable read-during-write result and optional post-reset zero sweep.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1,
    localparam int unsigned NUM_BYTES     = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_BYTES-1:0]  wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int unsigned DEPTH  = depth(ADDR_WIDTH);
    localparam bit          BYPASS = (RDW_MODE == RDW_NEW);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_err_bw
        $error("ram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_err_lat
        $error("ram_sdp_be: RD_LATENCY must be 1 or 2");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_err_rdw
        $error("ram_sdp_be: RDW_MODE must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    if (CLEAR_ON_RESET != 0) begin : g_clear
        ram_clear_fsm #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_clear (
            .clk      (clk),
            .rst      (rst),
            .busy     (init_busy),
            .clr_we   (clr_we),
            .clr_addr (clr_addr)
        );
    end else begin : g_no_clear
        assign init_busy = 1'b0;
        assign clr_we    = 1'b0;
        assign clr_addr  = '0;
    end

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_acc = wr_en && !init_busy && !rst;
    assign rd_acc = rd_en && !init_busy && !rst;

    // Enabled lanes take new data, the rest keep the stored word.
    always_comb begin
        wr_merged = mem[wr_addr];
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_be[i]) begin
                wr_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
        if (BYPASS && wr_acc && (wr_addr == rd_addr)) begin
            rd_word = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // Data registers only load on a completing read so rd_data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_data <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench: three 32-bit instances (old-data, new-data, latency-2) share stimulus;
// a fourth 64-bit/16-deep instance covers the wide configuration.
module tb_ram_sdp_be;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [6:0]  rd_addr;

    logic [31:0] rd_data_a, rd_data_b, rd_data_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic        init_busy_a, init_busy_b, init_busy_c;

    logic        wr_en_w;
    logic [3:0]  wr_addr_w;
    logic [3:0]  wr_be_w;
    logic [63:0] wr_data_w;
    logic        rd_en_w;
    logic [3:0]  rd_addr_w;
    logic [63:0] rd_data_w;
    logic        rd_valid_w;
    logic        init_busy_w;

    int vectors;
    int miscompares;

    ram_sdp_be #(.RD_LATENCY(1), .RDW_MODE(0)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .init_busy(init_busy_a));

    ram_sdp_be #(.RD_LATENCY(1), .RDW_MODE(1)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .init_busy(init_busy_b));

    ram_sdp_be #(.RD_LATENCY(2), .RDW_MODE(0)) u_dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c),
        .rd_valid(rd_valid_c), .init_busy(init_busy_c));

    ram_sdp_be #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .BYTE_WIDTH(16)) u_dut_w (
        .clk(clk), .rst(rst), .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_be(wr_be_w),
        .wr_data(wr_data_w), .rd_en(rd_en_w), .rd_addr(rd_addr_w), .rd_data(rd_data_w),
        .rd_valid(rd_valid_w), .init_busy(init_busy_w));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (rd_valid_a !== 1'b0 || rd_valid_c !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got a=%b c=%b expected 0", rd_valid_a, rd_valid_c);
        end
        vectors++;
        if (rd_data_a !== 32'h0 || rd_data_c !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got a=%h c=%h expected 0", rd_data_a, rd_data_c);
        end
        vectors++;
        if (init_busy_a !== 1'b1 || init_busy_w !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: got a=%b w=%b expected 1", init_busy_a, init_busy_w);
        end
    endtask

    task automatic test_clear_sweep();
        int n;
        int wn;
        logic [6:0] addrs [3];
        n = 300;
        wn = 0;
        addrs[0] = 7'd0; addrs[1] = 7'd64; addrs[2] = 7'd127;
        rst = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (init_busy_w !== 1'b1 && wn == 0) wn = i;
            if (init_busy_a !== 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != 128) begin
            miscompares++;
            $display("FAIL sweep_len: got %0d cycles expected 128", n);
        end
        vectors++;
        if (wn != 16) begin
            miscompares++;
            $display("FAIL wide_sweep_len: got %0d cycles expected 16", wn);
        end
        for (int k = 0; k < 3; k++) begin
            rd(addrs[k]);
            vectors++;
            if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin
                miscompares++;
                $display("FAIL clear_read[%0d]: got v=%b d=%h expected v=1 d=0", addrs[k], rd_valid_a, rd_data_a);
            end
            tick();
            vectors++;
            if (rd_valid_a !== 1'b0) begin
                miscompares++;
                $display("FAIL valid_pulse[%0d]: got %b expected 0", addrs[k], rd_valid_a);
            end
        end
    endtask

    task automatic test_byte_enables();
        wr(7'd5, 4'b1111, 32'hAABBCCDD);
        wr(7'd5, 4'b0101, 32'h11223344);
        rd(7'd5);
        vectors++;
        if (rd_data_a !== 32'hAA22CC44) begin
            miscompares++;
            $display("FAIL byte_en: got %h expected aa22cc44", rd_data_a);
        end
        wr(7'd5, 4'b0000, 32'h00000000);
        rd(7'd5);
        vectors++;
        if (rd_data_a !== 32'hAA22CC44) begin
            miscompares++;
            $display("FAIL be_zero_noop: got %h expected aa22cc44", rd_data_a);
        end
    endtask

    task automatic test_rdw();
        wr(7'd9, 4'b1111, 32'h12345678);
        wr_en = 1'b1; wr_addr = 7'd9; wr_be = 4'b0011; wr_data = 32'hFFFFFFFF;
        rd_en = 1'b1; rd_addr = 7'd9;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        vectors++;
        if (rd_data_a !== 32'h12345678) begin
            miscompares++;
            $display("FAIL rdw_old: got %h expected 12345678", rd_data_a);
        end
        vectors++;
        if (rd_data_b !== 32'h1234FFFF) begin
            miscompares++;
            $display("FAIL rdw_new: got %h expected 1234ffff", rd_data_b);
        end
        tick();
        vectors++;
        if (rd_valid_c !== 1'b1 || rd_data_c !== 32'h12345678) begin
            miscompares++;
            $display("FAIL rdw_old_lat2: got v=%b d=%h expected v=1 d=12345678", rd_valid_c, rd_data_c);
        end
        // Write to another address while reading 9: no bypass
        wr_en = 1'b1; wr_addr = 7'd10; wr_be = 4'b1111; wr_data = 32'hCAFEF00D;
        rd_en = 1'b1; rd_addr = 7'd9;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        vectors++;
        if (rd_data_a !== 32'h1234FFFF || rd_data_b !== 32'h1234FFFF) begin
            miscompares++;
            $display("FAIL rdw_diff_addr: got a=%h b=%h expected 1234ffff", rd_data_a, rd_data_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic       exp_v;
        for (int i = 0; i < 8; i++) wr(7'(i), 4'b1111, 32'(i));
        for (int i = 0; i < 12; i++) begin
            rd_en = (i < 8);
            rd_addr = 7'(i);
            tick();
            exp_v = (i >= 1 && i <= 8);
            vectors++;
            if (rd_valid_c !== exp_v || (exp_v && rd_data_c !== 32'(i - 1))) begin
                miscompares++;
                $display("FAIL lat2_stream[%0d]: got v=%b d=%h expected v=%b d=%h", i, rd_valid_c, rd_data_c, exp_v, 32'(i - 1));
            end
            if (i < 8) begin
                vectors++;
                if (rd_valid_a !== 1'b1 || rd_data_a !== 32'(i)) begin
                    miscompares++;
                    $display("FAIL lat1_stream[%0d]: got v=%b d=%h expected v=1 d=%h", i, rd_valid_a, rd_data_a, 32'(i));
                end
            end
            if (i > 8) begin
                vectors++;
                if (rd_data_c !== 32'd7) begin
                    miscompares++;
                    $display("FAIL lat2_hold[%0d]: got %h expected 7", i, rd_data_c);
                end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_busy_gating();
        int n;
        n = 300;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            if (i == 2) begin
                wr_en = 1'b1; wr_addr = 7'd3; wr_be = 4'b1111; wr_data = 32'hDEADBEEF;
                rd_en = 1'b1; rd_addr = 7'd3;
            end
            tick();
            wr_en = 1'b0; rd_en = 1'b0;
            if (i == 2) begin
                vectors++;
                if (rd_valid_a !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_rd_gate1: got %b expected 0", rd_valid_a);
                end
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            if (i == 120) begin
                wr_en = 1'b1; wr_addr = 7'd3; wr_be = 4'b1111; wr_data = 32'hDEADBEEF;
                rd_en = 1'b1; rd_addr = 7'd3;
            end
            tick();
            wr_en = 1'b0; rd_en = 1'b0;
            if (i == 120) begin
                vectors++;
                if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_rd_gate2: got a=%b b=%b expected 0", rd_valid_a, rd_valid_b);
                end
            end
            if (init_busy_a !== 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != 128) begin
            miscompares++;
            $display("FAIL restart_sweep_len: got %0d cycles expected 128", n);
        end
        rd(7'd3);
        vectors++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin
            miscompares++;
            $display("FAIL busy_wr_dropped: got v=%b d=%h expected v=1 d=0", rd_valid_a, rd_data_a);
        end
    endtask

    task automatic test_wide();
        rd_en_w = 1'b1; rd_addr_w = 4'd15;
        tick();
        rd_en_w = 1'b0;
        vectors++;
        if (rd_valid_w !== 1'b1 || rd_data_w !== 64'h0) begin
            miscompares++;
            $display("FAIL wide_cleared: got v=%b d=%h expected v=1 d=0", rd_valid_w, rd_data_w);
        end
        wr_en_w = 1'b1; wr_addr_w = 4'd15; wr_be_w = 4'b1111; wr_data_w = 64'h0123456789ABCDEF;
        tick();
        wr_be_w = 4'b1000; wr_data_w = 64'hFFFFEEEEDDDDCCCC;
        tick();
        wr_en_w = 1'b0;
        rd_en_w = 1'b1; rd_addr_w = 4'd15;
        tick();
        rd_en_w = 1'b0;
        vectors++;
        if (rd_valid_w !== 1'b1 || rd_data_w !== 64'hFFFF456789ABCDEF) begin
            miscompares++;
            $display("FAIL wide_be: got v=%b d=%h expected v=1 d=ffff456789abcdef", rd_valid_w, rd_data_w);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        wr_en_w = 1'b0; wr_addr_w = '0; wr_be_w = '0; wr_data_w = '0;
        rd_en_w = 1'b0; rd_addr_w = '0;
        vectors = 0;
        miscompares = 0;

        test_reset();
        test_clear_sweep();
        test_byte_enables();
        test_rdw();
        test_back_to_back();
        test_busy_gating();
        test_wide();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port synchronous RAM. It is the successor to the team's fixed 128x32 single-port RAM.
- Has one write port with per-byte enables and one independent read port.
- Read latency is configurable, read-during-write behaviour is defined, and an optional self-clear sweeps all memory to zero after reset.
- Sits as the shared buffer/register-file primitive behind the benchmark datapaths.

Parameters:
- DATA_WIDTH, 32, bits per word; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 7, address bits; DEPTH = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per byte-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- RD_LATENCY, 1, 1 = array read registered once; 2 = extra output register.
- RDW_MODE, 0, same-address read/write in the same cycle: 0 = old data, 1 = new (merged) data.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = no sweep, contents undefined after power-up.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_be  in  NUM_BYTES  byte-lane enables; bit i covers data[i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data carries the result of a read request this cycle.
- init_busy  out  1  clear sweep in progress; requests ignored.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rd_data=0, rd_valid=0, and the latency pipeline is flushed.
  - init_busy=1 if CLEAR_ON_RESET, else 0.
  - Memory contents are not touched during rst itself.
- Clear FSM, states IDLE and CLEAR; exists only when CLEAR_ON_RESET=1.
  - Reset enters CLEAR with clr_addr=0.
  - Each cycle with rst=0, the FSM writes 0 to mem[clr_addr] and increments clr_addr.
  - After writing DEPTH-1 the FSM goes to IDLE and init_busy drops on the next edge. The sweep occupies exactly DEPTH cycles after rst deasserts.
  - rst asserted mid-sweep restarts the sweep at 0.
  - While init_busy=1, wr_en and rd_en are ignored (no write, rd_valid stays 0). Requests are dropped, not queued.
- Write:
  - When wr_en=1 and init_busy=0, mem[wr_addr] lane i takes wr_data lane i where wr_be[i]=1. Other lanes keep their value.
  - wr_be=0 is a legal no-op.
- Read:
  - A rd_en=1 sampled at edge N gives rd_data=mem[rd_addr] and rd_valid=1 after edge N+RD_LATENCY-1. That is, visible in the cycle following edge N when RD_LATENCY=1.
  - rd_valid is a pure pipeline of accepted rd_en and is 1 for exactly one cycle per request.
  - Back-to-back reads sustain one result per cycle.
  - When no read completes, rd_data holds its last value (no X, no zeroing).
- Read-during-write (wr_en & rd_en, same address, same edge):
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word, i.e. new bytes on enabled lanes and old bytes elsewhere.
  - Different addresses do not interact.
- Undefined-data rule: never deliberately drive X. The generation-1 practice of writing X on non-write cycles is dropped.
- Elaboration checks:
  - DATA_WIDTH % BYTE_WIDTH != 0 is an error.
  - RD_LATENCY not in {1,2} is an error.
  - RDW_MODE not in {0,1} is an error.

Decomposition:
- Package ram_pkg:
  - localparams RDW_OLD=0 and RDW_NEW=1.
  - Clear-FSM state enum {ST_IDLE, ST_CLEAR}.
  - Functions num_bytes(dw,bw) and depth(aw).
- Sub-module ram_clear_fsm (clk, rst, busy, clr_we, clr_addr), instantiated only when CLEAR_ON_RESET=1.
- The array, byte-merge logic, RDW bypass mux and latency pipe stay in ram_sdp_be.

Test Plan:
- Clear sweep (defaults):
  - Stimulus: rst for 2 cycles, then release.
  - Expect: init_busy=1 for exactly 128 cycles, then 0. Reads of addresses 0, 64 and 127 return 0x00000000 with rd_valid pulsing 1 cycle after rd_en.
- Byte enables:
  - Stimulus: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101.
  - Expect: read of addr 5 returns 0xAA22CC44.
- Read-during-write:
  - Stimulus: addr 9 holds 0x12345678; same edge, write 0xFFFFFFFF with be=4'b0011 and read addr 9.
  - Expect: RDW_MODE=0 returns 0x12345678; RDW_MODE=1 returns 0x1234FFFF.
- Latency and throughput:
  - Stimulus: RD_LATENCY=2, 8 consecutive reads of addr 0..7 preloaded with value=addr.
  - Expect: rd_valid high for 8 cycles starting 2 cycles after the first rd_en; data 0..7 in order; rd_data holds 7 afterwards.
- Busy gating and mid-sweep reset:
  - Stimulus: during the sweep, wr_en to addr 3 with 0xDEADBEEF; then at sweep cycle 50, pulse rst.
  - Expect: the write is dropped (addr 3 reads 0); init_busy stays high for a full 128 cycles after the second rst release.
- Wide config:
  - Stimulus: DATA_WIDTH=64, ADDR_WIDTH=4, BYTE_WIDTH=16; write with be=4'b1000 to addr 15.
  - Expect: only bits [63:48] change; the sweep lasts 16 cycles.
